// File: rtl/fir_mc_serial.sv
// Multi-channel time-multiplexed FIR filter with one serial MAC, runtime-loadable
// coefficients, per-channel circular history, valid/ready on both sides and round/saturate output.
module fir_mc_serial #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned TAPS      = 401,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned ACC_W     = 48,
    parameter int unsigned OUT_SHIFT = 15,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned TA_W     = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sample,
    input  logic [CH_W-1:0]   in_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sample,
    output logic [CH_W-1:0]   out_chan,
    output logic              out_sat,
    input  logic              coef_we,
    input  logic [TA_W-1:0]   coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam logic [TA_W-1:0] LAST = TA_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] MAX_P = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_N = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (OUT_SHIFT - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state_q, state_d;

    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [DATA_W-1:0] hist [CHANNELS][TAPS];
    logic [TA_W-1:0]          wptr [CHANNELS];

    logic [CH_W-1:0]          chan;
    logic [TA_W-1:0]          base;
    logic [TA_W-1:0]          k;
    logic [TA_W-1:0]          rd_idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        sat_sample;
    logic                     sat_flag;
    logic                     accept;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and input handshake; a coefficient write blocks the input for that cycle
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !coef_we && !rst;
                accept   = in_valid && in_ready;
                if (accept) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (k == LAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Tap k reads the sample written k inputs ago on this channel, wrapping around the ring
    always_comb begin
        if (base >= k) begin
            rd_idx = base - k;
        end else begin
            rd_idx = TA_W'({1'b0, base} + (TA_W+1)'(TAPS) - {1'b0, k});
        end
        prod    = PROD_W'(coef[k]) * PROD_W'(hist[chan][rd_idx]);
        acc_sum = acc + ACC_W'(prod);
        rnd     = (acc_sum + HALF) >>> OUT_SHIFT;
        if (rnd > MAX_P) begin
            sat_sample = MAX_P[DATA_W-1:0];
            sat_flag   = 1'b1;
        end else if (rnd < MIN_N) begin
            sat_sample = MIN_N[DATA_W-1:0];
            sat_flag   = 1'b1;
        end else begin
            sat_sample = DATA_W'(rnd);
            sat_flag   = 1'b0;
        end
    end

    // Storage, MAC datapath and registered output; reset also clears coefficients and history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                coef[i] <= '0;
            end
            for (int c = 0; c < int'(CHANNELS); c++) begin
                wptr[c] <= '0;
                for (int i = 0; i < int'(TAPS); i++) begin
                    hist[c][i] <= '0;
                end
            end
            chan       <= '0;
            base       <= '0;
            k          <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_chan   <= '0;
            out_sat    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (coef_we) begin
                        coef[coef_addr] <= coef_data;
                    end
                    if (accept) begin
                        hist[in_chan][wptr[in_chan]] <= in_sample;
                        chan          <= in_chan;
                        base          <= wptr[in_chan];
                        wptr[in_chan] <= (wptr[in_chan] == LAST) ? '0 : wptr[in_chan] + TA_W'(1);
                        acc           <= '0;
                        k             <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    k   <= k + TA_W'(1);
                    if (k == LAST) begin
                        out_valid  <= 1'b1;
                        out_sample <= sat_sample;
                        out_sat    <= sat_flag;
                        out_chan   <= chan;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mc_serial.sv
// Bench for fir_mc_serial: two instances (OUT_SHIFT 1 and 15) share stimulus and are
// checked against a sum-of-products reference over a per-channel newest-first history.
module tb_fir_mc_serial;

    localparam int TAPS = 8;
    localparam int CH   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_sample = '0;
    logic        in_chan = 1'b0;
    logic        out_ready = 1'b0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;

    logic        a_in_ready, a_out_valid, a_out_sat, a_busy, a_out_chan;
    logic [15:0] a_out_sample;
    logic        b_in_ready, b_out_valid, b_out_sat, b_busy, b_out_chan;
    logic [15:0] b_out_sample;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int m_coef [TAPS];
    int m_hist [CH][TAPS];

    logic [15:0] o1, o15;
    logic        s15;

    fir_mc_serial #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .CHANNELS(CH), .ACC_W(48), .OUT_SHIFT(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_sample(in_sample),
        .in_chan(in_chan), .out_valid(a_out_valid), .out_ready(out_ready), .out_sample(a_out_sample),
        .out_chan(a_out_chan), .out_sat(a_out_sat), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .busy(a_busy));

    fir_mc_serial #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .CHANNELS(CH), .ACC_W(48), .OUT_SHIFT(15)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_sample(in_sample),
        .in_chan(in_chan), .out_valid(b_out_valid), .out_ready(out_ready), .out_sample(b_out_sample),
        .out_chan(b_out_chan), .out_sat(b_out_sat), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .busy(b_busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint m_sum(input int ch);
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(m_coef[i]) * longint'(m_hist[ch][i]);
        return s;
    endfunction

    // Round half toward +inf, then drop s fractional bits
    function automatic longint m_round(input longint y, input int s);
        return (y + (longint'(1) <<< (s - 1))) >>> s;
    endfunction

    function automatic logic [15:0] m_clip(input longint r);
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        return 16'(r);
    endfunction

    function automatic logic m_clipped(input longint r);
        return (r > 32767) || (r < -32768);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = 0;
            for (int c = 0; c < CH; c++) m_hist[c][i] = 0;
        end
    endtask

    task automatic wr_coef(input int a, input int v);
        logic signed [15:0] t;
        t = 16'(v);
        coef_we = 1'b1; coef_addr = 3'(a); coef_data = 16'(v);
        @(posedge clk); #1;
        coef_we = 1'b0;
        m_coef[a] = int'(t);
    endtask

    // One sample through the filter; hold = cycles of out_ready=0 while the result waits
    task automatic send(input int ch, input int smp, input int hold, input bit mac_we,
                        output logic [15:0] r1, output logic [15:0] r15, output logic sat15);
        int hs, n;
        longint y, y1, y15;
        logic signed [15:0] s16;
        s16 = 16'(smp);
        in_valid = 1'b1; in_chan = ch[0]; in_sample = 16'(smp);
        #1;
        check("in_ready_idle", {a_in_ready, b_in_ready}, 2'b11);
        hs = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = TAPS - 1; i > 0; i--) m_hist[ch][i] = m_hist[ch][i-1];
        m_hist[ch][0] = int'(s16);
        y = m_sum(ch); y1 = m_round(y, 1); y15 = m_round(y, 15);
        check("busy_mac", a_busy, 1'b1);
        n = 0;
        while (a_out_valid !== 1'b1 && n < 30) begin
            coef_we = mac_we && (n == 2);
            coef_addr = 3'd2; coef_data = 16'h1234;
            #1;
            if (n == 2) check("in_ready_mac", a_in_ready, 1'b0);
            @(posedge clk); #1;
            n++;
        end
        coef_we = 1'b0;
        check("latency", 64'(cyc - hs), 64'(TAPS + 1));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_sample = 16'($urandom);
            #1;
            check("bp_in_ready", {a_in_ready, b_in_ready}, 2'b00);
            check("bp_valid", a_out_valid, 1'b1);
            check("bp_sample", a_out_sample, m_clip(y1));
            check("bp_chan", a_out_chan, ch[0]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("a_sample", a_out_sample, m_clip(y1));
        check("a_sat", a_out_sat, m_clipped(y1));
        check("a_chan", a_out_chan, ch[0]);
        check("b_valid", b_out_valid, 1'b1);
        check("b_sample", b_out_sample, m_clip(y15));
        check("b_sat", b_out_sat, m_clipped(y15));
        check("b_chan", b_out_chan, ch[0]);
        r1 = a_out_sample; r15 = b_out_sample; sat15 = b_out_sat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", {a_out_valid, b_out_valid}, 2'b00);
        check("busy_idle", a_busy, 1'b0);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {a_in_ready, b_in_ready}, 2'b00);
        check("rst_valid", {a_out_valid, b_out_valid}, 2'b00);
        check("rst_sample", {a_out_sample, b_out_sample}, 32'h0);
        check("rst_chan_sat", {a_out_chan, a_out_sat, b_out_chan, b_out_sat}, 4'b0000);
        check("rst_busy", {a_busy, b_busy}, 2'b00);
        rst = 1'b0;
        #1;
        check("idle_in_ready", a_in_ready, 1'b1);

        // Impulse: scaled-by-2 impulse on ch0 returns the coefficients
        for (int i = 0; i < TAPS; i++) wr_coef(i, i + 1);
        for (int i = 0; i <= TAPS; i++) begin
            send(0, (i == 0) ? 2 : 0, 0, 1'b0, o1, o15, s15);
            check("impulse", o1, 16'((i < TAPS) ? i + 1 : 0));
        end

        // Channel isolation: ch0 impulse interleaved with ch1 constant 4
        for (int i = 0; i < TAPS; i++) begin
            send(0, (i == 0) ? 2 : 0, 0, 1'b0, o1, o15, s15);
            check("iso_ch0", o1, 16'(i + 1));
            send(1, 4, (i == 3) ? 5 : 0, 1'b0, o1, o15, s15);
            check("iso_ch1", o1, 16'((i + 1) * (i + 2)));
        end

        // Rounding at OUT_SHIFT=15
        for (int i = 0; i < TAPS; i++) wr_coef(i, (i == 0) ? 16'h4000 : 0);
        send(1, 3, 0, 1'b0, o1, o15, s15);
        check("round_pos", o15, 16'd2);
        send(1, -3, 0, 1'b0, o1, o15, s15);
        check("round_neg", o15, 16'hFFFF);

        // Saturation both ways
        for (int i = 0; i < TAPS; i++) wr_coef(i, 16'h7FFF);
        for (int i = 0; i < TAPS; i++) send(0, 32767, 0, 1'b0, o1, o15, s15);
        check("sat_pos", {o15, s15}, {16'h7FFF, 1'b1});
        for (int i = 0; i < TAPS; i++) send(0, -32768, 0, 1'b0, o1, o15, s15);
        check("sat_neg", {o15, s15}, {16'h8000, 1'b1});

        // Coefficient write colliding with an input, then a write attempt during MAC
        for (int i = 0; i < TAPS; i++) wr_coef(i, i + 1);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd3;
        in_valid = 1'b1; in_chan = 1'b0; in_sample = 16'd77;
        #1;
        check("collide_in_ready", {a_in_ready, b_in_ready}, 2'b00);
        @(posedge clk); #1;
        coef_we = 1'b0; in_valid = 1'b0;
        m_coef[0] = 3;
        check("collide_no_hs", a_busy, 1'b0);
        send(1, 0, 0, 1'b1, o1, o15, s15);
        for (int i = 1; i < TAPS; i++) send(1, 0, 0, 1'b0, o1, o15, s15);
        send(1, 2, 0, 1'b0, o1, o15, s15);
        check("collide_tap0", o1, 16'd3);
        send(1, 0, 0, 1'b0, o1, o15, s15);
        check("collide_tap1", o1, 16'd2);
        send(1, 0, 0, 1'b0, o1, o15, s15);
        check("mac_we_ignored", o1, 16'd3);

        // Reset during MAC at k=3
        in_valid = 1'b1; in_chan = 1'b0; in_sample = 16'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", a_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {a_busy, b_busy}, 2'b00);
        check("mid_rst_valid", {a_out_valid, b_out_valid}, 2'b00);
        check("mid_rst_out", {a_out_sample, a_out_chan, a_out_sat}, 18'h0);
        check("mid_rst_in_ready", a_in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("post_rst_in_ready", a_in_ready, 1'b1);
        send(0, 2, 0, 1'b0, o1, o15, s15);
        check("zero_coef", {o1, o15}, 32'h0);
        for (int i = 0; i < TAPS; i++) wr_coef(i, i + 1);
        send(0, 0, 0, 1'b0, o1, o15, s15);
        check("hist_cleared", o1, 16'd2);

        // Randomised traffic
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                wr_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 65535)));
            end else begin
                send(int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 3)), 1'b0, o1, o15, s15);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
